// File: rtl/phase_sequencer.sv
// Phase timing generator and run/stop controller for the 16-bit processor.
// Produces one-hot p0..p(N-1), exec/halted status and a retired-instruction count.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exec_btn,
  input  logic                  step_btn,
  input  logic                  stop_flag,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  p0,
  output logic                  exec,
  output logic                  halted,
  output logic                  inst_done,
  output logic [CNT_W-1:0]      instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALT
  } state_t;

  localparam logic [NUM_PHASES-1:0] PHASE_P0 = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                state_nxt;
  logic                  stop_pend;
  logic                  stop_pend_nxt;
  logic [NUM_PHASES-1:0] phase_nxt;

  logic exec_s1, exec_s2, exec_q;
  logic step_s1, step_s2, step_q;
  logic exec_edge, step_edge;
  logic active, last_phase;

  // Button synchronisers followed by a rising-edge register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exec_s1 <= 1'b0;
      exec_s2 <= 1'b0;
      exec_q  <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      exec_s1 <= exec_btn;
      exec_s2 <= exec_s1;
      exec_q  <= exec_s2;
      step_s1 <= step_btn;
      step_s2 <= step_s1;
      step_q  <= step_s2;
    end
  end

  assign exec_edge  = exec_s2 & ~exec_q;
  assign step_edge  = step_s2 & ~step_q;
  assign active     = (state == RUN) || (state == STEP);
  assign last_phase = phase[NUM_PHASES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stop_pend <= 1'b0;
      phase     <= PHASE_P0;
    end else begin
      state     <= state_nxt;
      stop_pend <= stop_pend_nxt;
      phase     <= phase_nxt;
    end
  end

  // Rotation out of the last phase lands on p0, so the next instruction
  // (or the parked p0 in IDLE/HALT) needs no separate case.
  always_comb begin
    state_nxt     = state;
    stop_pend_nxt = stop_pend;
    phase_nxt     = PHASE_P0;
    if (active) begin
      phase_nxt = {phase[NUM_PHASES-2:0], phase[NUM_PHASES-1]};
    end
    unique case (state)
      IDLE: begin
        stop_pend_nxt = 1'b0;
        if (exec_edge) begin
          state_nxt = RUN;
        end else if (step_edge) begin
          state_nxt = STEP;
        end
      end
      RUN: begin
        if (exec_edge) begin
          stop_pend_nxt = 1'b1;
        end
        if (last_phase) begin
          if (stop_flag) begin
            state_nxt     = HALT;
            stop_pend_nxt = 1'b0;
          end else if (stop_pend || exec_edge) begin
            state_nxt     = IDLE;
            stop_pend_nxt = 1'b0;
          end
        end
      end
      STEP: begin
        stop_pend_nxt = 1'b0;
        if (last_phase) begin
          state_nxt = stop_flag ? HALT : IDLE;
        end
      end
      HALT: begin
        stop_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
    end else if (active && last_phase) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  assign p0        = phase[0];
  assign exec      = active;
  assign halted    = (state == HALT);
  assign inst_done = active & last_phase;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Generates the per-instruction phase timing (p0–p4) and the run/stop state for the 16-bit processor.
- Sits directly upstream of the combinational control decoder:
  - Supplies its `exec` and `p0` inputs.
  - Consumes the decoder's `stop_flag`, which the HLT instruction raises.
- Also synchronises the run and single-step push-buttons and counts retired instructions.

## Interface
Parameters:
- `NUM_PHASES`, default 5: phases per instruction (p0..p4). Minimum 2.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting 0 resets all state immediately.
- `exec_btn`  in  1: run/stop push-button level. Asynchronous to `clk`, pre-debounced.
- `step_btn`  in  1: single-step push-button level. Asynchronous, pre-debounced.
- `stop_flag`  in  1: from the control decoder. 1 means halt after the current instruction.
- `phase`  out  NUM_PHASES: one-hot phase vector. Bit k means phase pk.
- `p0`  out  1: equals `phase[0]`.
- `exec`  out  1: 1 while an instruction is executing (state RUN or STEP).
- `halted`  out  1: 1 in state HALT.
- `inst_done`  out  1: 1 during the last phase of an instruction in RUN or STEP.
- `instr_count`  out  CNT_W: number of retired instructions.

## Operation
- Input conditioning:
  - `exec_btn` and `step_btn` each pass through a 2-flop synchroniser, then an edge register.
  - `exec_edge` = sync2 & ~edge_reg; `step_edge` is formed the same way.
  - The edge terms are single-cycle.
- States: IDLE, RUN, STEP, HALT.
- IDLE:
  - `phase` is held at p0; `exec`=0.
  - `exec_edge` → RUN.
  - `step_edge` (without `exec_edge`) → STEP.
  - If both edges occur together, `exec_edge` wins.
- RUN:
  - `phase` rotates one position per clock: p0→p1→…→p(N-1)→p0.
  - `exec_edge` sets `stop_pend`.
  - At the end of the last phase (the edge leaving p(N-1)), the first matching rule applies:
    - If `stop_flag`=1 → HALT.
    - Else if `stop_pend` or `exec_edge` → IDLE, and `stop_pend` clears.
    - Else continue in RUN at p0.
- STEP:
  - Same phase rotation for exactly one instruction.
  - At the end of p(N-1): `stop_flag` → HALT, else → IDLE.
  - `exec_edge` and `step_edge` are ignored in STEP.
- HALT:
  - `phase` is held at p0; `exec`=0; `halted`=1.
  - All button edges are ignored. Only `rst` exits HALT.
- `stop_flag` is sampled only in the last phase of RUN/STEP. Its value in other phases or states is ignored.
- `inst_done` = (state ∈ {RUN, STEP}) & `phase[N-1]`. It is decoded from registers only, with no combinational path from the inputs.
- `instr_count`:
  - Increments by 1 on every clock edge where `inst_done`=1, including the instruction that leads to HALT.
  - Wraps modulo 2^CNT_W, with no saturation.
- Whenever `exec`=0, `phase` is p0. The decoder therefore drives all enables low.

## Timing
- Reset values:
  - `phase`=one-hot p0 (…0001); `p0`=1.
  - `exec`=0, `halted`=0, `inst_done`=0, `instr_count`=0.
  - State=IDLE; `stop_pend`=0; all synchroniser and edge flops = 0.
- Button latency: `exec_btn` first sampled high at edge N → `exec_edge` high in cycle N+1..N+2 → state RUN and `exec`=1 after edge N+2. The first p1 appears after edge N+3.
- Instruction length: exactly `NUM_PHASES` cycles. Consecutive instructions in RUN have no bubble.
- Stop latency: the instruction in progress always completes. `exec` falls at the edge that ends p(N-1).
- A button held high produces only one edge. A new edge requires the level to return to 0 for at least 1 sampled cycle.
- Reset mid-instruction: outputs return to reset values asynchronously. The partially executed instruction is not counted.
- Reset release: the first state change is possible at the first `clk` edge after release.

## Test plan
- Reset, idle: hold `rst`=0 for 3 cycles, then release with no buttons → `phase`=00001, `exec`=0, `instr_count`=0 for 20 cycles.
- Run, then stop: pulse `exec_btn` high for 4 cycles, run 23 cycles, pulse again mid-instruction (at p2).
  - Required: `exec`=1 two edges after first sampling.
  - Required: phases cycle 00001→00010→…→10000 with no gaps.
  - Required: the stop takes effect only after p4; `instr_count` equals the number of completed p4s.
- Single step: pulse `step_btn` in IDLE → exactly 5 cycles with `exec`=1, one `inst_done` pulse, `instr_count`=1, return to IDLE. A second `exec_btn` pulse during the step is ignored.
- HLT: in RUN, assert `stop_flag` during p2 only → no effect. Assert it during p4 → HALT, `halted`=1, `phase`=00001. Subsequent `exec_btn` and `step_btn` pulses produce no change; `rst` returns to IDLE.
- Simultaneous events:
  - `exec_btn` and `step_btn` edges in the same cycle in IDLE → RUN.
  - `stop_flag`=1 and `exec_edge` at p4 → HALT (not IDLE).
- Wrap and reset: with `CNT_W`=4, run 17 instructions → `instr_count`=1. Assert `rst` during p3 → all outputs are at reset values before the next `clk` edge.
